// File: rtl/sd_crc_pkg.sv
// Shared definitions for the SD CRC engine.
//   state_t    : engine control states
//   CRC7_POLY  : x^7 + x^3 + 1 (SD command CRC)
//   CRC16_POLY : x^16 + x^12 + x^5 + 1 (SD data CRC)
//   crc_step   : one serial LFSR step on a left-justified 16-bit register
package sd_crc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        APPEND,
        RXCRC,
        RESULT
    } state_t;

    localparam logic [6:0]  CRC7_POLY  = 7'h09;
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // Widest CRC supported by crc_step.
    localparam int CRC_MAX_W = 16;

    // crc and poly are left-justified in 16 bits so a single function serves
    // every width up to 16: the register MSB always sits at bit 15 and the
    // unused low bits stay zero because only zeros are shifted in.
    function automatic logic [15:0] crc_step(input logic [15:0] crc,
                                             input logic        bit_in,
                                             input logic [15:0] poly);
        logic fb;
        fb = bit_in ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc_fold.sv
// Combinational fold of one DATA_W-bit beat into a CRC_W-bit register.
//   crc_in  : register value before the beat
//   data    : beat, MSB processed first
//   crc_out : register value after all DATA_W bits
module sd_crc_fold #(
    parameter int                CRC_W  = 7,
    parameter int                DATA_W = 1,
    parameter logic [CRC_W-1:0]  POLY   = 7'h09
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_out
);
    import sd_crc_pkg::*;

    localparam int          PAD     = CRC_MAX_W - CRC_W;
    localparam logic [15:0] POLY_AL = 16'(POLY) << PAD;

    if (CRC_W > CRC_MAX_W || CRC_W < 2) begin : g_bad_crc_w
        $error("sd_crc_fold: CRC_W must be between 2 and 16");
    end

    logic [15:0] acc;

    always_comb begin
        acc = 16'(crc_in) << PAD;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            acc = crc_step(acc, data[i], POLY_AL);
        end
        crc_out = CRC_W'(acc >> PAD);
    end

endmodule

// File: rtl/sd_crc_engine.sv
// SD CRC generator / checker with valid/ready streaming interfaces.
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   mode                  : 0 = generate (pass data, append CRC), 1 = check;
//                           taken from the first beat of each frame
//   s_valid/s_ready/s_last/s_data : input stream, MSB first
//   m_valid/m_ready/m_last/m_data : generate-mode output stream
//   chk_valid/chk_ok      : one-cycle check result
//   busy                  : engine is inside a frame
module sd_crc_engine #(
    parameter int               CRC_W  = 7,
    parameter logic [CRC_W-1:0] POLY   = 7'h09,
    parameter int               DATA_W = 1,
    parameter logic [CRC_W-1:0] INIT   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              s_valid,
    input  logic              s_last,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic              m_last,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              chk_valid,
    output logic              chk_ok,
    output logic              busy
);
    import sd_crc_pkg::*;

    if (CRC_W % DATA_W != 0) begin : g_bad_data_w
        $error("sd_crc_engine: CRC_W must be a multiple of DATA_W");
    end

    localparam int               NBEATS    = CRC_W / DATA_W;
    localparam int               CNT_W     = $clog2(NBEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    state_t           state;
    logic [CRC_W-1:0] crc;
    logic [CRC_W-1:0] rx;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;

    logic [CRC_W-1:0] crc_src;
    logic [CRC_W-1:0] crc_fold;
    logic [CRC_W-1:0] crc_shl;
    logic [CRC_W-1:0] rx_next;
    logic             s_fire;
    logic             m_fire;

    // A frame always starts from INIT, whatever the register held before.
    assign crc_src = (state == IDLE) ? INIT : crc;

    sd_crc_fold #(
        .CRC_W  (CRC_W),
        .DATA_W (DATA_W),
        .POLY   (POLY)
    ) u_fold (
        .crc_in  (crc_src),
        .data    (s_data),
        .crc_out (crc_fold)
    );

    // Current APPEND beat sits in the top DATA_W bits after shifting out
    // the beats already sent.
    assign crc_shl = crc << (cnt * DATA_W);
    assign rx_next = CRC_W'({rx, s_data});
    assign s_fire  = s_valid && s_ready;
    assign m_fire  = m_valid && m_ready;
    assign busy    = (state != IDLE);

    // Stream handshakes are combinational so generate-mode data passes with
    // zero latency; everything is forced low while reset is asserted.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        unique case (state)
            IDLE, DATA: begin
                // In IDLE the live mode input decides, since this beat is
                // the one that latches it.
                if ((state == IDLE) ? mode : mode_q) begin
                    s_ready = 1'b1;
                end else begin
                    s_ready = m_ready;
                    m_valid = s_valid;
                    m_data  = s_data;
                end
            end
            APPEND: begin
                m_valid = 1'b1;
                m_data  = crc_shl[CRC_W-1 -: DATA_W];
                m_last  = (cnt == LAST_BEAT);
            end
            RXCRC: begin
                s_ready = 1'b1;
            end
            default: begin
            end
        endcase
        if (!rst_n) begin
            s_ready = 1'b0;
            m_valid = 1'b0;
            m_last  = 1'b0;
            m_data  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            crc       <= INIT;
            rx        <= '0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            chk_valid <= 1'b0;
            chk_ok    <= 1'b0;
        end else begin
            chk_valid <= 1'b0;
            chk_ok    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (s_fire) begin
                        mode_q <= mode;
                        crc    <= crc_fold;
                        cnt    <= '0;
                        rx     <= '0;
                        if (s_last) begin
                            state <= mode ? RXCRC : APPEND;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (s_fire) begin
                        crc <= crc_fold;
                        if (s_last) begin
                            cnt   <= '0;
                            state <= mode_q ? RXCRC : APPEND;
                        end
                    end
                end
                APPEND: begin
                    if (m_fire) begin
                        if (cnt == LAST_BEAT) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RXCRC: begin
                    // s_last carries no meaning here; the beat count ends it.
                    if (s_fire) begin
                        rx <= rx_next;
                        if (cnt == LAST_BEAT) begin
                            cnt       <= '0;
                            chk_valid <= 1'b1;
                            chk_ok    <= (rx_next == crc);
                            state     <= RESULT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RESULT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_crc_engine.sv
module tb_sd_crc_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   sel = 0;

    logic        g_mode = 1'b0;
    logic        g_s_valid = 1'b0;
    logic        g_s_last = 1'b0;
    logic        g_m_ready = 1'b0;
    logic [15:0] g_s_data = 16'h0;

    logic        g_s_ready, g_m_valid, g_m_last, g_chk_valid, g_chk_ok, g_busy;
    logic [15:0] g_m_data;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // lane 0: CRC7 / 1 bit, lane 1: CRC16 / 8 bit, lane 2: CRC16 / 16 bit
    logic sv0, sr0, mv0, ml0, cv0, co0, b0;
    logic sv1, sr1, mv1, ml1, cv1, co1, b1;
    logic sv2, sr2, mv2, ml2, cv2, co2, b2;
    logic [0:0]  md0;
    logic [7:0]  md1;
    logic [15:0] md2;

    assign sv0 = g_s_valid && (sel == 0);
    assign sv1 = g_s_valid && (sel == 1);
    assign sv2 = g_s_valid && (sel == 2);

    sd_crc_engine #(.CRC_W(7), .POLY(7'h09), .DATA_W(1), .INIT(7'h00)) u_crc7 (
        .clk(clk), .rst_n(rst_n), .mode(g_mode), .s_valid(sv0), .s_last(g_s_last),
        .s_data(g_s_data[0:0]), .s_ready(sr0), .m_valid(mv0), .m_last(ml0), .m_data(md0),
        .m_ready(g_m_ready), .chk_valid(cv0), .chk_ok(co0), .busy(b0));

    sd_crc_engine #(.CRC_W(16), .POLY(16'h1021), .DATA_W(8), .INIT(16'h0000)) u_crc16b (
        .clk(clk), .rst_n(rst_n), .mode(g_mode), .s_valid(sv1), .s_last(g_s_last),
        .s_data(g_s_data[7:0]), .s_ready(sr1), .m_valid(mv1), .m_last(ml1), .m_data(md1),
        .m_ready(g_m_ready), .chk_valid(cv1), .chk_ok(co1), .busy(b1));

    sd_crc_engine #(.CRC_W(16), .POLY(16'h1021), .DATA_W(16), .INIT(16'h0000)) u_crc16w (
        .clk(clk), .rst_n(rst_n), .mode(g_mode), .s_valid(sv2), .s_last(g_s_last),
        .s_data(g_s_data), .s_ready(sr2), .m_valid(mv2), .m_last(ml2), .m_data(md2),
        .m_ready(g_m_ready), .chk_valid(cv2), .chk_ok(co2), .busy(b2));

    always_comb begin
        case (sel)
            1: begin
                g_s_ready = sr1; g_m_valid = mv1; g_m_last = ml1; g_m_data = 16'(md1);
                g_chk_valid = cv1; g_chk_ok = co1; g_busy = b1;
            end
            2: begin
                g_s_ready = sr2; g_m_valid = mv2; g_m_last = ml2; g_m_data = md2;
                g_chk_valid = cv2; g_chk_ok = co2; g_busy = b2;
            end
            default: begin
                g_s_ready = sr0; g_m_valid = mv0; g_m_last = ml0; g_m_data = 16'(md0);
                g_chk_valid = cv0; g_chk_ok = co0; g_busy = b0;
            end
        endcase
    end

    function automatic int lane_dw(input int l);
        return (l == 0) ? 1 : ((l == 1) ? 8 : 16);
    endfunction

    function automatic int lane_cw(input int l);
        return (l == 0) ? 7 : 16;
    endfunction

    function automatic logic [15:0] lane_poly(input int l);
        return (l == 0) ? 16'h0009 : 16'h1021;
    endfunction

    // Reference: remainder of M(x) * x^w divided by G(x) = x^w + poly,
    // computed by mod-2 long division on an explicit bit array.
    function automatic logic [15:0] ref_crc(input logic msg[$], input int w,
                                            input logic [15:0] poly);
        logic a[];
        logic [15:0] r;
        int n;
        n = msg.size();
        a = new[n + w];
        for (int i = 0; i < n + w; i++) a[i] = (i < n) ? msg[i] : 1'b0;
        for (int i = 0; i < n; i++) begin
            if (a[i]) begin
                a[i] = 1'b0;
                for (int j = 0; j < w; j++) a[i + 1 + j] = a[i + 1 + j] ^ poly[w - 1 - j];
            end
        end
        r = 16'h0;
        for (int j = 0; j < w; j++) r[w - 1 - j] = a[n + j];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame on a lane and checks everything observable about it.
    task automatic do_frame(input string name, input int lane, input logic md,
                            input logic dbits[$], input logic [15:0] rxc, input bit rnd,
                            input bit have_exp, input logic [15:0] exp_crc, input logic exp_ok,
                            output logic obits[$]);
        int dw, w, nd, nr, idx, cyc, nlast, last_pos, hold_err, r;
        bit started, done, pend, prev_stall, got_chk;
        logic ok;
        logic [15:0] beat, mask, prev_data, refc, got_crc, want_crc;
        dw = lane_dw(lane);
        w = lane_cw(lane);
        nd = dbits.size() / dw;
        nr = md ? (w / dw) : 0;
        mask = (dw == 16) ? 16'hFFFF : 16'((32'h1 << dw) - 1);
        refc = ref_crc(dbits, w, lane_poly(lane));
        obits.delete();
        idx = 0; cyc = 0; nlast = 0; last_pos = -1; hold_err = 0;
        started = 0; done = 0; pend = 0; prev_stall = 0; got_chk = 0; ok = 1'b0;
        prev_data = 16'h0;
        sel = lane;
        @(posedge clk); #1;
        while (!done && cyc < 5000) begin
            if (!pend) begin
                if (idx < nd + nr) begin
                    g_s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                    beat = 16'h0;
                    if (idx < nd) begin
                        for (int k = 0; k < dw; k++) beat[dw - 1 - k] = dbits[idx * dw + k];
                        g_s_last = (idx == nd - 1);
                    end else begin
                        r = idx - nd;
                        beat = 16'(rxc >> (w - (r + 1) * dw)) & mask;
                        g_s_last = 1'($urandom);
                    end
                    g_s_data = beat;
                end else begin
                    g_s_valid = 1'b0;
                    g_s_last = 1'b0;
                end
            end
            g_mode = started ? 1'($urandom) : md;
            g_m_ready = rnd ? 1'($urandom) : 1'b1;
            @(negedge clk);
            if (prev_stall && (!g_m_valid || g_m_data !== prev_data)) hold_err++;
            prev_stall = g_m_valid && !g_m_ready;
            prev_data = g_m_data;
            if (g_m_valid && g_m_ready) begin
                for (int k = 0; k < dw; k++) obits.push_back(g_m_data[dw - 1 - k]);
                if (g_m_last) begin
                    nlast++;
                    last_pos = obits.size();
                    if (!md) done = 1;
                end
            end
            if (g_chk_valid) begin
                got_chk = 1;
                ok = g_chk_ok;
                done = 1;
            end
            if (g_s_valid && g_s_ready) begin
                idx++;
                started = 1;
                pend = 0;
            end else begin
                pend = g_s_valid;
            end
            @(posedge clk); #1;
            cyc++;
        end
        g_s_valid = 1'b0;
        g_s_last = 1'b0;
        g_m_ready = 1'b1;
        check({name, "_timeout"}, 32'(!done), 32'd0);
        check({name, "_stall_hold"}, 32'(hold_err), 32'd0);
        if (!md) begin
            want_crc = have_exp ? exp_crc : refc;
            check({name, "_out_len"}, 32'(obits.size()), 32'(dbits.size() + w));
            r = 0;
            for (int i = 0; i < dbits.size() && i < obits.size(); i++)
                if (obits[i] !== dbits[i]) r++;
            check({name, "_passthru"}, 32'(r), 32'd0);
            got_crc = 16'h0;
            if (obits.size() >= w)
                for (int j = 0; j < w; j++) got_crc = {got_crc[14:0], obits[obits.size() - w + j]};
            check({name, "_crc"}, 32'(got_crc), 32'(want_crc));
            check({name, "_nlast"}, 32'(nlast), 32'd1);
            check({name, "_last_pos"}, 32'(last_pos), 32'(obits.size()));
            check({name, "_no_chk"}, 32'(got_chk), 32'd0);
        end else begin
            check({name, "_chk_seen"}, 32'(got_chk), 32'd1);
            check({name, "_chk_ok"}, 32'(ok), have_exp ? 32'(exp_ok) : 32'(rxc == refc));
            check({name, "_no_mout"}, 32'(obits.size()), 32'd0);
        end
        @(negedge clk);
        check({name, "_pulse_end"}, 32'(g_chk_valid), 32'd0);
        check({name, "_idle_after"}, 32'(g_busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_s_ready"}, 32'(g_s_ready), 32'd0);
        check({name, "_m_valid"}, 32'(g_m_valid), 32'd0);
        check({name, "_m_last"}, 32'(g_m_last), 32'd0);
        check({name, "_m_data"}, 32'(g_m_data), 32'd0);
        check({name, "_chk_valid"}, 32'(g_chk_valid), 32'd0);
        check({name, "_chk_ok"}, 32'(g_chk_ok), 32'd0);
        check({name, "_busy"}, 32'(g_busy), 32'd0);
    endtask

    // Start a lane-0 frame, pulse reset after n accepted beats, confirm no result.
    task automatic abort_frame(input string name, input logic md, input logic bits[$], input int n);
        bit cv_seen;
        sel = 0;
        g_m_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            g_mode = (i == 0) ? md : 1'($urandom);
            g_s_valid = 1'b1;
            g_s_data = 16'(bits[i]);
            g_s_last = (i == 39);
            @(posedge clk); #1;
        end
        g_s_valid = 1'b0;
        g_s_last = 1'b0;
        check({name, "_busy_mid"}, 32'(g_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(name);
        cv_seen = 0;
        repeat (2) begin
            @(negedge clk);
            cv_seen = cv_seen | g_chk_valid;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        g_mode = 1'b0;
        @(negedge clk);
        check({name, "_ready_rise"}, 32'(g_s_ready), 32'd1);
        repeat (4) begin
            cv_seen = cv_seen | g_chk_valid;
            @(negedge clk);
        end
        check({name, "_no_chk"}, 32'(cv_seen), 32'd0);
    endtask

    typedef struct {
        int          lane;
        logic        md;
        int          nbytes;
        logic [71:0] data;
        logic [15:0] rxc;
        logic [15:0] exp_crc;
        logic        exp_ok;
    } vec_t;

    initial begin
        vec_t vt[9];
        logic bits[$];
        logic o1[$];
        logic o2[$];
        logic cmd0[$];
        logic [15:0] refc, rxc;
        int n, diff, dw;
        logic md;

        vt[0] = '{0, 1'b0, 5, 72'h40_0000_0000, 16'h0000, 16'h004A, 1'b0};
        vt[1] = '{0, 1'b0, 5, 72'h48_0000_01AA, 16'h0000, 16'h0043, 1'b0};
        vt[2] = '{0, 1'b0, 5, 72'h51_0000_0000, 16'h0000, 16'h002A, 1'b0};
        vt[3] = '{0, 1'b1, 5, 72'h40_0000_0000, 16'h004A, 16'h0000, 1'b1};
        vt[4] = '{0, 1'b1, 5, 72'h40_0000_0000, 16'h004B, 16'h0000, 1'b0};
        vt[5] = '{0, 1'b1, 5, 72'h48_0000_01AA, 16'h0043, 16'h0000, 1'b1};
        vt[6] = '{1, 1'b0, 9, 72'h31_3233_3435_3637_3839, 16'h0000, 16'h31C3, 1'b0};
        vt[7] = '{1, 1'b1, 9, 72'h31_3233_3435_3637_3839, 16'h31C3, 16'h0000, 1'b1};
        vt[8] = '{2, 1'b0, 2, 72'h0000, 16'h0000, 16'h0000, 1'b0};

        // reset values on every lane
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 3; l++) begin
            sel = l;
            #1;
            check_reset_outputs($sformatf("reset_l%0d", l));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        sel = 0;
        g_m_ready = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(g_s_ready), 32'd1);

        // table-driven frames
        for (int v = 0; v < 9; v++) begin
            bits.delete();
            for (int b = 0; b < vt[v].nbytes; b++)
                for (int k = 7; k >= 0; k--) bits.push_back(vt[v].data[8 * (vt[v].nbytes - 1 - b) + k]);
            do_frame($sformatf("vec%0d", v), vt[v].lane, vt[v].md, bits, vt[v].rxc,
                     (v % 2) == 1, 1'b1, vt[v].exp_crc, vt[v].exp_ok, o1);
        end

        // 512 bytes of 0xFF, without and with random stalls
        bits.delete();
        for (int i = 0; i < 4096; i++) bits.push_back(1'b1);
        do_frame("ff512", 1, 1'b0, bits, 16'h0, 1'b0, 1'b1, 16'h7FA1, 1'b0, o1);
        do_frame("ff512_stall", 1, 1'b0, bits, 16'h0, 1'b1, 1'b1, 16'h7FA1, 1'b0, o2);
        diff = (o1.size() == o2.size()) ? 0 : 1;
        for (int i = 0; i < o1.size() && i < o2.size(); i++) if (o1[i] !== o2[i]) diff++;
        check("ff512_same_output", 32'(diff), 32'd0);

        // random frames on every lane against the division model
        for (int l = 0; l < 3; l++) begin
            dw = lane_dw(l);
            for (int f = 0; f < 8; f++) begin
                bits.delete();
                n = $urandom_range(1, 6) * ((l == 0) ? 7 : 16);
                for (int i = 0; i < n; i++) bits.push_back(1'($urandom));
                md = 1'($urandom);
                refc = ref_crc(bits, lane_cw(l), lane_poly(l));
                rxc = refc;
                if ($urandom_range(0, 1) == 1) rxc[$urandom_range(0, lane_cw(l) - 1)] ^= 1'b1;
                do_frame($sformatf("rnd_l%0d_f%0d", l, f), l, md, bits, rxc, 1'b1,
                         1'b0, 16'h0, 1'b0, o1);
            end
        end

        // mid-frame reset, then a clean CMD0
        cmd0.delete();
        for (int i = 0; i < 40; i++) cmd0.push_back(i == 1);
        abort_frame("rst_gen", 1'b0, cmd0, 20);
        do_frame("cmd0_after_rst", 0, 1'b0, cmd0, 16'h0, 1'b0, 1'b1, 16'h004A, 1'b0, o1);
        abort_frame("rst_chk", 1'b1, cmd0, 40);
        do_frame("chk_after_rst", 0, 1'b1, cmd0, 16'h004A, 1'b0, 1'b1, 16'h0, 1'b1, o1);

        // single-beat frame, 16-bit lane, cycle by cycle with an APPEND stall
        sel = 2;
        bits.delete();
        for (int k = 15; k >= 0; k--) bits.push_back(refc[k] ^ refc[k]);
        rxc = 16'h1234;
        bits.delete();
        for (int k = 15; k >= 0; k--) bits.push_back(rxc[k]);
        refc = ref_crc(bits, 16, 16'h1021);
        @(posedge clk); #1;
        g_mode = 1'b0; g_s_valid = 1'b1; g_s_data = 16'h1234; g_s_last = 1'b1; g_m_ready = 1'b1;
        @(negedge clk);
        check("w16_first_m_valid", 32'(g_m_valid), 32'd1);
        check("w16_first_m_data", 32'(g_m_data), 32'h1234);
        check("w16_first_m_last", 32'(g_m_last), 32'd0);
        @(posedge clk); #1;
        g_s_valid = 1'b0; g_s_last = 1'b0; g_m_ready = 1'b0;
        @(negedge clk);
        check("w16_app_busy", 32'(g_busy), 32'd1);
        check("w16_app_s_ready", 32'(g_s_ready), 32'd0);
        check("w16_app_data", 32'(g_m_data), 32'(refc));
        @(posedge clk); #1;
        g_m_ready = 1'b1;
        @(negedge clk);
        check("w16_app_held_valid", 32'(g_m_valid), 32'd1);
        check("w16_app_held_data", 32'(g_m_data), 32'(refc));
        check("w16_app_last", 32'(g_m_last), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("w16_app_done", 32'(g_busy), 32'd0);

        // check mode on the 16-bit lane: RESULT refuses input
        @(posedge clk); #1;
        g_mode = 1'b1; g_s_valid = 1'b1; g_s_data = 16'h1234; g_s_last = 1'b1;
        @(posedge clk); #1;
        g_mode = 1'b0; g_s_data = refc; g_s_last = 1'b0;
        @(negedge clk);
        check("w16_rx_ready", 32'(g_s_ready), 32'd1);
        check("w16_rx_no_mvalid", 32'(g_m_valid), 32'd0);
        @(posedge clk); #1;
        g_s_data = 16'hBEEF;
        @(negedge clk);
        check("w16_result_valid", 32'(g_chk_valid), 32'd1);
        check("w16_result_ok", 32'(g_chk_ok), 32'd1);
        check("w16_result_s_ready", 32'(g_s_ready), 32'd0);
        @(posedge clk); #1;
        g_s_valid = 1'b0;
        @(negedge clk);
        check("w16_result_pulse", 32'(g_chk_valid), 32'd0);
        check("w16_result_idle", 32'(g_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
